// File: rtl/rr_mux_reg_pkg.sv
// rr_mux_pkg: shared constants and helpers for the rr_mux_reg channel merger.
//   MODE_RR    : round-robin arbitration, pointer advances past each winner
//   MODE_FIXED : fixed priority, lowest channel index wins, pointer frozen
package rr_mux_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Index after idx in a ring of n entries.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if: handshake bundle between N producers and one consumer.
//   mode              : 0 round-robin, 1 fixed priority
//   in_data/in_valid  : per-channel payload and request (producer side)
//   in_ready          : per-channel accept, one-hot or zero
//   out_data/out_sel  : registered payload and the channel it came from
//   out_valid/out_ready : downstream handshake
// slave is the merger's view; master is the environment's view.
interface rr_mux_reg_if #(
   parameter int N     = 4,
   parameter int WIDTH = 64
);
   localparam int SEL_W = $clog2(N);

   logic                     mode;
   logic [N-1:0][WIDTH-1:0]  in_data;
   logic [N-1:0]             in_valid;
   logic [N-1:0]             in_ready;
   logic [WIDTH-1:0]         out_data;
   logic [SEL_W-1:0]         out_sel;
   logic                     out_valid;
   logic                     out_ready;

   modport slave  (input  mode, in_data, in_valid, out_ready,
                   output in_ready, out_data, out_sel, out_valid);
   modport master (output mode, in_data, in_valid, out_ready,
                   input  in_ready, out_data, out_sel, out_valid);
endinterface

// File: rtl/rr_mux_reg_arbiter.sv
// rr_arbiter: combinational N-way arbiter.
//   req   : per-channel request
//   ptr   : round-robin start index (ignored in fixed mode)
//   mode  : MODE_RR scans ptr..ptr+N-1 mod N, MODE_FIXED scans 0..N-1
//   grant : index of the first requesting channel in scan order
//   any   : at least one request present
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             mode,
   output logic [SEL_W-1:0] grant,
   output logic             any
);
   logic [SEL_W-1:0] start;
   logic [SEL_W:0]   idx;   // one extra bit so start+k never overflows before wrap

   always_comb begin
      start = (mode == MODE_FIXED) ? '0 : ptr;
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, start} + (SEL_W+1)'(k);
         if (idx >= (SEL_W+1)'(N)) idx = idx - (SEL_W+1)'(N);
         if (!any && req[idx[SEL_W-1:0]]) begin
            any   = 1'b1;
            grant = idx[SEL_W-1:0];
         end
      end
   end
endmodule

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N:1 registered channel merger with internal arbitration.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : rr_mux_reg_if slave (mode, in_*, out_*)
// The output register refills in the same cycle it drains, so a held-high
// out_ready gives one beat per cycle.
module rr_mux_reg
   import rr_mux_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int N     = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   rr_mux_reg_if.slave    bus
);
   localparam int SEL_W = $clog2(N);

   logic [SEL_W-1:0]        ptr;
   logic [SEL_W-1:0]        grant;
   logic                    any;
   logic                    load;
   logic [N-1:0][WIDTH-1:0] masked;
   logic [WIDTH-1:0]        mux_data;
   logic [WIDTH-1:0]        out_data_q;
   logic [SEL_W-1:0]        out_sel_q;
   logic                    out_valid_q;

   rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
      .req   (bus.in_valid),
      .ptr   (ptr),
      .mode  (bus.mode),
      .grant (grant),
      .any   (any)
   );

   // reset_n term keeps in_ready low while reset is held (out_valid is 0 then).
   assign load = reset_n && any && (!out_valid_q || bus.out_ready);

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign masked[i]       = (grant == SEL_W'(i)) ? bus.in_data[i] : '0;
      assign bus.in_ready[i] = load && (grant == SEL_W'(i));
   end

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N; i++) mux_data = mux_data | masked[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr         <= '0;
      end else if (load) begin
         out_data_q  <= mux_data;
         out_sel_q   <= grant;
         out_valid_q <= 1'b1;
         if (bus.mode == MODE_RR) ptr <= SEL_W'(wrap_inc(int'(grant), N));
      end else if (bus.out_ready) begin
         // drain with nothing to refill; payload keeps its last value
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
module tb_rr_mux_reg;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   logic [3:0][63:0] din;
   logic [65:0]      sb[$];      // {sel, data} expected per accepted beat
   logic [1:0]       last_sel;
   logic [63:0]      last_data;

   rr_mux_reg_if #(.N(4), .WIDTH(64)) bus ();
   assign bus.in_data = din;

   rr_mux_reg #(.WIDTH(64), .N(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] r = '0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   // Drive in_valid, check in_ready, push expected beat, clock, then pop and check.
   task automatic step(input string tag, input logic [3:0] v, input logic [3:0] er, input logic eov);
      logic [1:0]  s;
      logic [65:0] e;
      bus.in_valid = v;
      #1;
      chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(er));
      if (er != 4'b0000) begin
         s = oh2idx(er);
         sb.push_back({s, din[s]});
      end
      @(posedge clk); #1;
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(eov));
      if (er != 4'b0000) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s.scoreboard: observed empty expected entry", tag);
         end else begin
            e = sb.pop_front();
            last_sel  = e[65:64];
            last_data = e[63:0];
         end
      end
      chk({tag, ".out_sel"}, 64'(bus.out_sel), 64'(last_sel));
      chk({tag, ".out_data"}, bus.out_data, last_data);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) din[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 32'h1111);
      last_sel      = '0;
      last_data     = '0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 4'b1111;
      reset_n       = 1'b0;

      // reset with all channels requesting
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst.out_data",  bus.out_data,       64'd0);
      chk("rst.out_sel",   64'(bus.out_sel),   64'd0);
      chk("rst.in_ready",  64'(bus.in_ready),  64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      reset_n = 1'b0; #1; reset_n = 1'b1;   // clean restart after settle

      // round-robin rotation, first grant from index 0
      step("rr0", 4'b1111, 4'b0001, 1'b1);
      step("rr1", 4'b1111, 4'b0010, 1'b1);
      step("rr2", 4'b1111, 4'b0100, 1'b1);
      step("rr3", 4'b1111, 4'b1000, 1'b1);
      step("rr4", 4'b1111, 4'b0001, 1'b1);   // ptr now 1

      // fixed priority: channel 1 always, 3 never; ptr frozen at 1
      bus.mode = 1'b1;
      step("fx0", 4'b1010, 4'b0010, 1'b1);
      step("fx1", 4'b1010, 4'b0010, 1'b1);
      step("fx2", 4'b1010, 4'b0010, 1'b1);

      // backpressure: beat from ch1 held, DEAD_BEEF waits on ch2
      bus.mode      = 1'b0;
      din[2]        = 64'h0000_0000_DEAD_BEEF;
      bus.out_ready = 1'b0;
      step("bp0", 4'b0100, 4'b0000, 1'b1);
      step("bp1", 4'b0100, 4'b0000, 1'b1);
      step("bp2", 4'b0100, 4'b0000, 1'b1);
      bus.out_ready = 1'b1;
      step("bp3", 4'b0100, 4'b0100, 1'b1);   // drain and load same cycle, ptr 3

      // wrap: ptr 3, only ch0 -> grant 0, ptr 1
      step("wr0", 4'b0001, 4'b0001, 1'b1);
      step("wr1", 4'b1111, 4'b0010, 1'b1);   // confirms ptr was 1

      // drain to empty: payload retained
      step("dr0", 4'b0000, 4'b0000, 1'b0);
      step("dr1", 4'b0000, 4'b0000, 1'b0);

      // fixed priority with everything requesting
      bus.mode = 1'b1;
      step("fx3", 4'b1111, 4'b0001, 1'b1);

      // asynchronous reset mid-stream: outputs clear without a clock edge
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst.out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst.out_data",  bus.out_data,       64'd0);
      chk("arst.in_ready",  64'(bus.in_ready),  64'd0);
      last_sel  = '0;
      last_data = '0;
      @(negedge clk);
      reset_n  = 1'b1;
      bus.mode = 1'b0;
      step("arst.rr", 4'b1110, 4'b0010, 1'b1);
      step("arst.rr2", 4'b1110, 4'b0100, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised N-input, WIDTH-bit registered multiplexer with an internal arbiter and valid/ready handshake. It generalises the single-bit-select 2:1 mux used on register-address and datapath selects into a sequential N:1 channel merger that picks among concurrently valid sources itself. Fixed-priority or round-robin selection is chosen at run time. It sits wherever several producers share one downstream consumer in the pipelined CPU, e.g. merging writeback or memory-request sources.

## Interface
- WIDTH, 64, data bits per channel (≥1)
- N, 4, number of input channels (≥2)
- SEL_W, $clog2(N), width of the channel index (derived; not overridden)

- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_data  in  N×WIDTH  per-channel payload
- in_valid  in  N  per-channel request
- in_ready  out  N  per-channel accept (one-hot or zero)
- out_data  out  WIDTH  registered payload
- out_sel  out  SEL_W  index of the channel that produced out_data
- out_valid  out  1  out_data/out_sel hold a beat
- out_ready  in  1  consumer accepts the current beat

## Operation
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. in_ready=0 while in reset.
- load = (|in_valid) && (!out_valid || out_ready). Output register can refill in the same cycle it drains.
- Grant (combinational): round-robin scans indices ptr, ptr+1, … mod N, first valid wins; fixed priority scans 0..N-1.
- in_ready[g] = load && (grant==g); all other in_ready bits 0. A beat transfers on channel i when in_valid[i] && in_ready[i].
- On load: out_data←in_data[g], out_sel←g, out_valid←1. Round-robin mode: ptr←(g+1) mod N (wrap from N-1 to 0). Fixed mode: ptr unchanged.
- No load and out_ready && out_valid: out_valid←0; out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_data, out_sel, out_valid hold; ptr holds; in_ready all 0.
- Mode change takes effect on the next grant evaluation; ptr is preserved across mode changes.
- Inputs need not hold in_valid when not granted; the block adds no fairness memory beyond ptr.

## Timing
- Latency: 1 cycle from accepted input beat to out_valid.
- Throughput: 1 beat/cycle while out_ready held high.
- in_ready depends combinationally on in_valid, out_valid, out_ready, mode, ptr; outputs out_* are registered only.
- Simultaneous drain and load in one cycle: out_valid stays 1, new beat replaces old; no bubble.
- Reset asserted mid-transfer: pending beat discarded, all outputs to reset values immediately; first grant after release starts from index 0.

## Structure
- Package rr_mux_pkg: mode encoding constants (MODE_RR=1'b0, MODE_FIXED=1'b1).
- One combinational sub-module, rr_arbiter (parameters N; inputs req[N], ptr, mode; outputs grant index and any). rr_mux_reg holds ptr and the output register and selects in_data[grant] with a generate loop.

## Test plan
- Reset: drive reset_n low with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0; release, out_ready=1 -> first out_sel=0, one cycle after release.
- Round-robin, N=4, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0,… one beat per cycle, in_ready one-hot matching.
- Fixed priority, mode=1, in_valid=4'b1010 -> out_sel=1 every cycle; channel 3 never granted.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_data[2]=64'hDEAD_BEEF pending -> out_data/out_sel unchanged, in_ready=0; out_ready=1 -> old beat leaves and DEAD_BEEF beat (out_sel=2) loads same cycle.
- Wrap: ptr=3 after grant to 2, in_valid=4'b0001 -> grant 0, ptr becomes 1.
- Drain to empty: single beat, then in_valid=0, out_ready=1 -> out_valid falls after one cycle, out_data retains last value.
